// File: rtl/mem_load_unit.sv
// ============================================================================
//  Module      : mem_load_unit
//  Description : Load-path front end of the multicycle datapath. Accepts a
//                one-cycle load command, runs the read handshake with data
//                memory, captures the returned word into the memory data
//                register (MDR) and presents the word, byte and halfword
//                results extended to 32 bits for the downstream select mux.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk          in   1   system clock, rising edge
//    reset        in   1   asynchronous, active-low reset
//    load_start   in   1   one-cycle load command, sampled only in IDLE
//    load_type    in   2   00 word, 01 byte, 10 half, 11 illegal
//    load_signed  in   1   1 = sign-extend byte/half, 0 = zero-extend
//    addr_lo      in   2   address bits [1:0] of the load
//    mem_rdata    in  32   data-memory read data
//    mem_ready    in   1   memory read data valid this cycle
//    mem_rd       out  1   read request, high for the whole request phase
//    busy         out  1   high in every state except IDLE
//    done         out  1   one-cycle pulse, results valid from this cycle
//    misaligned   out  1   one-cycle fault pulse
//    timeout      out  1   one-cycle fault pulse
//    wordB        out 32   MDR contents
//    byteB        out 32   selected byte, extended
//    halfB        out 32   selected halfword, extended
// ============================================================================
`default_nettype none

module mem_load_unit #(
  parameter int TIMEOUT = 15  // request cycles without mem_ready before abort, 1..255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_start,
  input  logic [1:0]  load_type,
  input  logic        load_signed,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        mem_rd,
  output logic        busy,
  output logic        done,
  output logic        misaligned,
  output logic        timeout,
  output logic [31:0] wordB,
  output logic [31:0] byteB,
  output logic [31:0] halfB
);

  localparam logic [7:0] C_TIMEOUT = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_DONE  = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] mdr_q, mdr_d;
  // Command fields, latched when a load is accepted.
  logic [1:0]  cmd_addr_q, cmd_addr_d;
  logic        cmd_signed_q, cmd_signed_d;
  // Fields that go with the MDR contents. They are copied from the command
  // fields only on a successful capture, so a faulted load cannot disturb the
  // byte/half results of the previous good load.
  logic [1:0]  res_addr_q, res_addr_d;
  logic        res_signed_q, res_signed_d;
  // Fault cause: 1 = timeout, 0 = misaligned.
  logic        cause_q, cause_d;

  logic        cmd_misaligned;
  logic [7:0]  cnt_inc;

  // The alignment check is made on the live command inputs in the accept
  // cycle, so load_type never needs to be kept past that edge.
  always_comb begin
    cmd_misaligned = 1'b0;
    case (load_type)
      2'b00:   cmd_misaligned = (addr_lo != 2'b00);
      2'b01:   cmd_misaligned = 1'b0;
      2'b10:   cmd_misaligned = addr_lo[0];
      default: cmd_misaligned = 1'b1;
    endcase
  end

  assign cnt_inc = cnt_q + 8'd1;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    mdr_d        = mdr_q;
    cmd_addr_d   = cmd_addr_q;
    cmd_signed_d = cmd_signed_q;
    res_addr_d   = res_addr_q;
    res_signed_d = res_signed_q;
    cause_d      = cause_q;
    mem_rd       = 1'b0;
    done         = 1'b0;
    misaligned   = 1'b0;
    timeout      = 1'b0;
    busy         = (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        if (load_start) begin
          cmd_addr_d   = addr_lo;
          cmd_signed_d = load_signed;
          if (cmd_misaligned) begin
            cause_d = 1'b0;
            state_d = S_FAULT;
          end else begin
            cnt_d   = 8'd0;
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        mem_rd = 1'b1;
        // A capture in the same cycle the counter would hit the limit wins.
        if (mem_ready) begin
          mdr_d        = mem_rdata;
          res_addr_d   = cmd_addr_q;
          res_signed_d = cmd_signed_q;
          state_d      = S_DONE;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == C_TIMEOUT) begin
            cause_d = 1'b1;
            state_d = S_FAULT;
          end
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      S_FAULT: begin
        misaligned = ~cause_q;
        timeout    = cause_q;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= 8'd0;
      mdr_q        <= 32'd0;
      cmd_addr_q   <= 2'd0;
      cmd_signed_q <= 1'b0;
      res_addr_q   <= 2'd0;
      res_signed_q <= 1'b0;
      cause_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      mdr_q        <= mdr_d;
      cmd_addr_q   <= cmd_addr_d;
      cmd_signed_q <= cmd_signed_d;
      res_addr_q   <= res_addr_d;
      res_signed_q <= res_signed_d;
      cause_q      <= cause_d;
    end
  end

  // Little-endian lane selection from the MDR.
  logic [31:0] byte_shift;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  assign byte_shift = mdr_q >> {res_addr_q, 3'b000};
  assign byte_lane  = byte_shift[7:0];
  assign half_lane  = res_addr_q[1] ? mdr_q[31:16] : mdr_q[15:0];

  assign wordB = mdr_q;
  assign byteB = {{24{res_signed_q & byte_lane[7]}}, byte_lane};
  assign halfB = {{16{res_signed_q & half_lane[15]}}, half_lane};

endmodule

`default_nettype wire

// File: tb/tb_mem_load_unit.sv
// ============================================================================
//  Module      : tb_mem_load_unit
//  Description : Self-checking bench for mem_load_unit. Stimulus pushes the
//                expected response of each load into a queue; an independent
//                monitor pops and compares whenever a done/fault pulse shows.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_load_unit;

  localparam int TO = 15;
  localparam logic [31:0] D = 32'h8123_F0A5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_start = 1'b0;
  logic [1:0]  load_type = 2'b00;
  logic        load_signed = 1'b0;
  logic [1:0]  addr_lo = 2'b00;
  logic [31:0] mem_rdata = 32'd0;
  logic        mem_ready = 1'b0;
  logic        mem_rd, busy, done, misaligned, timeout;
  logic [31:0] wordB, byteB, halfB;

  mem_load_unit #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(rst_n), .load_start(load_start), .load_type(load_type),
    .load_signed(load_signed), .addr_lo(addr_lo), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .mem_rd(mem_rd), .busy(busy), .done(done),
    .misaligned(misaligned), .timeout(timeout), .wordB(wordB),
    .byteB(byteB), .halfB(halfB)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_word = 32'd0;
  logic [1:0]  m_addr = 2'd0;
  logic        m_sgn  = 1'b0;

  function automatic logic [31:0] m_byte(input logic [31:0] w, input logic [1:0] a, input logic s);
    logic [31:0] v;
    v = (w / (32'd1 << (8 * a))) % 32'd256;
    if (s && v >= 32'd128) v = v + 32'hFFFF_FF00;
    return v;
  endfunction

  function automatic logic [31:0] m_half(input logic [31:0] w, input logic [1:0] a, input logic s);
    logic [31:0] v;
    v = (a >= 2'd2) ? (w / 32'd65536) : (w % 32'd65536);
    if (s && v >= 32'd32768) v = v + 32'hFFFF_0000;
    return v;
  endfunction

  typedef struct {
    logic [2:0]  kind;   // {done, misaligned, timeout}
    int          cyc;
    logic [31:0] w, b, h;
  } exp_t;

  exp_t q[$];

  // ---------------- monitor ----------------
  exp_t mon_e;
  logic prev_pulse = 1'b0;
  always @(negedge clk) begin
    if (prev_pulse) check("busy_after_pulse", {31'd0, busy}, 32'd0);
    prev_pulse = done | misaligned | timeout;
    if (done | misaligned | timeout) begin
      check("busy_in_pulse", {31'd0, busy}, 32'd1);
      if (q.size() == 0) begin
        check("unexpected_pulse", {29'd0, done, misaligned, timeout}, 32'd0);
      end else begin
        mon_e = q.pop_front();
        check("resp_kind", {29'd0, done, misaligned, timeout}, {29'd0, mon_e.kind});
        check("resp_cycle", cyc, mon_e.cyc);
        check("wordB", wordB, mon_e.w);
        check("byteB", byteB, mon_e.b);
        check("halfB", halfB, mon_e.h);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      load_start = 1'b0;
      mem_ready  = 1'($urandom);
      mem_rdata  = $urandom;
    end
  endtask

  // k = REQ cycle (1-based) in which mem_ready is raised; 0 = never.
  task automatic do_load(input logic [1:0] t, input logic s, input logic [1:0] a,
                         input logic [31:0] d, input int k);
    exp_t e;
    int   resp_j, rd_cnt, exp_rd, start_cyc;
    bit   mis, spur_end;
    mis = (t == 2'b11) || (t == 2'b00 && a != 2'b00) || (t == 2'b10 && a[0]);
    spur_end = 1'($urandom);
    @(negedge clk);
    load_start = 1'b1; load_type = t; load_signed = s; addr_lo = a;
    mem_ready = 1'b0;
    start_cyc = cyc;
    if (mis) begin
      resp_j = 1; exp_rd = 0; e.kind = 3'b010;
    end else if (k >= 1 && k <= TO) begin
      resp_j = k + 1; exp_rd = k; e.kind = 3'b100;
      m_word = d; m_addr = a; m_sgn = s;
    end else begin
      resp_j = TO + 1; exp_rd = TO; e.kind = 3'b001;
    end
    e.cyc = start_cyc + resp_j;
    e.w = m_word;
    e.b = m_byte(m_word, m_addr, m_sgn);
    e.h = m_half(m_word, m_addr, m_sgn);
    q.push_back(e);
    rd_cnt = 0;
    for (int j = 1; j <= resp_j; j++) begin
      @(negedge clk);
      // Starts issued while busy or in the DONE/FAULT cycle must be dropped.
      load_start = (j == 1 && resp_j > 1) || (j == resp_j && spur_end);
      if (load_start) begin
        load_type = 2'($urandom); load_signed = 1'($urandom); addr_lo = 2'($urandom);
      end
      mem_ready = (j == k);
      mem_rdata = (j == k) ? d : $urandom;
      rd_cnt += int'(mem_rd);
    end
    check("mem_rd_cycles", rd_cnt, exp_rd);
  endtask

  task automatic reset_midload();
    @(negedge clk);
    load_start = 1'b1; load_type = 2'b00; load_signed = 1'b0; addr_lo = 2'b00;
    mem_ready = 1'b0;
    repeat (2) begin
      @(negedge clk);
      load_start = 1'b0; mem_ready = 1'b0;
    end
    @(negedge clk);            // cycle 3 of the stalled load
    rst_n = 1'b0;
    #1;
    check("midreset_ctrl", {27'd0, mem_rd, busy, done, misaligned, timeout}, 32'd0);
    check("midreset_wordB", wordB, 32'd0);
    check("midreset_byteB", byteB, 32'd0);
    check("midreset_halfB", halfB, 32'd0);
    m_word = 32'd0; m_addr = 2'd0; m_sgn = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(2);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_ctrl", {27'd0, mem_rd, busy, done, misaligned, timeout}, 32'd0);
    check("reset_wordB", wordB, 32'd0);
    check("reset_byteB", byteB, 32'd0);
    check("reset_halfB", halfB, 32'd0);
    rst_n = 1'b1;
    idle(2);

    do_load(2'b00, 1'b0, 2'b00, D, 1);    // word
    do_load(2'b01, 1'b1, 2'b00, D, 1);    // FFFFFFA5
    do_load(2'b01, 1'b0, 2'b11, D, 2);    // 00000081
    do_load(2'b01, 1'b1, 2'b01, D, 1);    // FFFFFFF0
    do_load(2'b10, 1'b1, 2'b10, D, 1);    // FFFF8123
    do_load(2'b10, 1'b0, 2'b00, D, 3);    // 0000F0A5
    do_load(2'b10, 1'b0, 2'b01, 32'hDEAD_BEEF, 1);  // misaligned half
    do_load(2'b00, 1'b0, 2'b10, 32'hDEAD_BEEF, 1);  // misaligned word
    do_load(2'b11, 1'b1, 2'b00, 32'hDEAD_BEEF, 1);  // illegal type
    do_load(2'b00, 1'b0, 2'b00, 32'h1234_5678, 0);  // timeout
    do_load(2'b00, 1'b0, 2'b00, 32'h7654_3210, TO); // capture on last cycle
    reset_midload();

    for (int i = 0; i < 60; i++) begin
      int k;
      k = ($urandom_range(0, 3) == 0) ? $urandom_range(1, TO + 2) : $urandom_range(1, 3);
      do_load(2'($urandom), 1'($urandom), 2'($urandom), $urandom, k);
      idle($urandom_range(0, 2));
    end

    idle(3);
    check("queue_empty", q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
